// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
//
// Sends one command byte to a PS/2 device over the shared ps2 clock/data lines:
// inhibit (hold clock low), request-to-send (data low, clock released), then
// eight data bits LSB first, odd parity and the stop bit, each driven on a
// device clock fall, and finally samples the device ACK on the eleventh fall.
// Lines are driven open-drain through active-high pull-low enables.
//
// Optional feature (macro PS2_TX_RETRY_EN): a NACK or timeout restarts the
// frame from inhibit with the latched byte, up to MAX_RETRY extra attempts;
// tx_error_o pulses only after the final attempt fails. Without the macro the
// first failure pulses tx_error_o and MAX_RETRY has no effect.
//
// Ports:
//   clock_i        system clock (50 MHz nominal)
//   reset_i        asynchronous reset, active high
//   tx_valid_i     send request, accepted when tx_valid_i & tx_ready_o
//   tx_data_i      byte to send
//   tx_ready_o     high while idle
//   busy_o         ~tx_ready_o; lets the receiver ignore the line
//   tx_done_o      one-cycle pulse, device ACKed
//   tx_error_o     one-cycle pulse, NACK or timeout
//   ps2_clk_i      raw PS/2 clock pin
//   ps2_data_i     raw PS/2 data pin
//   ps2_clk_oe_o   1 = pull PS/2 clock low
//   ps2_data_oe_o  1 = pull PS/2 data low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       tx_error_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    // The attempt counter is two bits wide.
    if (MAX_RETRY > 3) begin : g_retry_check
        $error("MAX_RETRY does not fit the 2-bit attempt counter");
    end

    typedef enum logic [3:0] {
        StIdle,
        StInhibit,
        StStart,     // start bit driven, clock still held for one cycle
        StRts,
        StData,
        StStop,
        StAck,
        StWaitIdle,
        StFail
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [8:0]      shift_q;
    logic            clk_oe_q, data_oe_q;
    logic            tx_ready_q, tx_done_q, tx_error_q;
    logic            clk_meta_q, clk_sync_q, clk_prev_q;
    logic            data_meta_q, data_sync_q;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]      attempt_q;
`endif

    logic fall;
    logic in_frame;
    logic tmo_hit;

    // Synchronizers reset to the idle-high line level so no false fall is seen.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall     = clk_prev_q & ~clk_sync_q;
    assign in_frame = (state_q == StRts) || (state_q == StData) || (state_q == StStop) ||
                      (state_q == StAck) || (state_q == StWaitIdle);
    assign tmo_hit  = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            attempt_q  <= '0;
`endif
        end else begin
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            if (in_frame && tmo_hit) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                state_q   <= StFail;
            end else begin
                if (in_frame) begin
                    cnt_q <= cnt_q + CntW'(1);
                end
                unique case (state_q)
                    StIdle: begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        cnt_q      <= '0;
                        // Stays low for the first idle cycle after done/error.
                        tx_ready_q <= 1'b1;
                        if (tx_valid_i && tx_ready_q) begin
                            shift_q    <= {~^tx_data_i, tx_data_i};
                            tx_ready_q <= 1'b0;
                            clk_oe_q   <= 1'b1;
                            state_q    <= StInhibit;
`ifdef PS2_TX_RETRY_EN
                            attempt_q  <= '0;
`endif
                        end
                    end
                    StInhibit: begin
                        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                            data_oe_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= StStart;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StStart: begin
                        clk_oe_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StRts;
                    end
                    StRts: begin
                        if (fall) begin
                            data_oe_q <= ~shift_q[0];
                            bit_cnt_q <= 4'd1;
                            state_q   <= StData;
                        end
                    end
                    StData: begin
                        // bit_cnt_q == 8 selects the parity bit.
                        if (fall) begin
                            data_oe_q <= ~shift_q[bit_cnt_q];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd8) begin
                                state_q <= StStop;
                            end
                        end
                    end
                    StStop: begin
                        if (fall) begin
                            data_oe_q <= 1'b0;
                            state_q   <= StAck;
                        end
                    end
                    StAck: begin
                        if (fall) begin
                            state_q <= data_sync_q ? StFail : StWaitIdle;
                        end
                    end
                    StWaitIdle: begin
                        if (clk_sync_q && data_sync_q) begin
                            tx_done_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                    StFail: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                        if (attempt_q < 2'(MAX_RETRY)) begin
                            attempt_q <= attempt_q + 2'd1;
                            clk_oe_q  <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= StInhibit;
                        end else begin
                            tx_error_q <= 1'b1;
                            state_q    <= StIdle;
                        end
`else
                        tx_error_q <= 1'b1;
                        state_q    <= StIdle;
`endif
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign tx_ready_o    = tx_ready_q;
    assign busy_o        = ~tx_ready_q;
    assign tx_done_o     = tx_done_q;
    assign tx_error_o    = tx_error_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, a scoreboard queue holds the expected outcome of every send, and a
// monitor checks each tx_done/tx_error pulse against it.
module tb_ps2_host_tx;

    localparam int unsigned INH    = 60;
    localparam int unsigned TMO    = 2000;
    localparam int unsigned RETRY  = 2;
    localparam int          H      = 20;     // device half clock period, cycles
    localparam int          BUDGET = 12000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       clk_oe, data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY     (RETRY)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .tx_valid_i   (tx_valid),
        .tx_data_i    (tx_data),
        .tx_ready_o   (tx_ready),
        .busy_o       (busy),
        .tx_done_o    (tx_done),
        .tx_error_o   (tx_error),
        .ps2_clk_i    (ps2_clk_line),
        .ps2_data_i   (ps2_data_line),
        .ps2_clk_oe_o (clk_oe),
        .ps2_data_oe_o(data_oe)
    );

    typedef struct packed {
        logic [9:0] bits;
        bit         is_done;
        bit         is_timeout;
        int         attempts;
        int         frames;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] dev_frames[$];
    int         inh_runs[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int dev_mode = 0;          // 0 ACK, 1 NACK, 2 never clocks
    int dev_falls = 0;
    bit dev_busy = 0;
    bit post_pending = 0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    // Line bits seen by the device, in order: data LSB first, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    // Device model.
    initial begin
        logic [9:0] f;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && data_oe && !clk_oe) begin
                dev_busy = 1;
                if (dev_mode == 2) begin
                    while (data_oe && !clk_oe) @(negedge clk);
                end else begin
                    dev_falls = 0;
                    repeat (10) @(negedge clk);
                    for (int k = 0; k < 10; k++) begin
                        dev_clk_low = 1'b1;
                        dev_falls++;
                        repeat (H) @(negedge clk);
                        dev_clk_low = 1'b0;
                        f[k] = ps2_data_line;
                        repeat (H) @(negedge clk);
                    end
                    dev_frames.push_back(f);
                    if (dev_mode == 0) dev_data_low = 1'b1;
                    repeat (H / 2) @(negedge clk);
                    dev_clk_low = 1'b1;
                    dev_falls++;
                    repeat (H) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (H / 2) @(negedge clk);
                    dev_data_low = 1'b0;
                end
                dev_busy = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int   run;
        bit   prev_clk_oe;
        int   rts_cyc;
        exp_t e;
        run = 0;
        prev_clk_oe = 0;
        rts_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                run = 0;
                prev_clk_oe = 0;
                post_pending = 0;
            end else begin
                if (post_pending) begin
                    post_pending = 0;
                    check("post_ready", tx_ready, 1);
                    check("post_pulse_low", {tx_done, tx_error}, 0);
                    check("post_lines_released", {clk_oe, data_oe}, 0);
                end
                if (clk_oe && !data_oe) run++;
                else if (run > 0) begin
                    inh_runs.push_back(run);
                    run = 0;
                end
                if (prev_clk_oe && !clk_oe && data_oe) rts_cyc = cyc;
                prev_clk_oe = clk_oe;
                if (tx_done || tx_error) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {tx_done, tx_error}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("outcome_done", tx_done, e.is_done);
                        check("outcome_error", tx_error, !e.is_done);
                        check("inhibit_phases", inh_runs.size(), e.attempts);
                        foreach (inh_runs[i]) check("inhibit_len", inh_runs[i], INH);
                        check("frames_seen", dev_frames.size(), e.frames);
                        if (e.is_done && dev_frames.size() > 0)
                            check("frame_bits", dev_frames[0], e.bits);
                        if (e.is_timeout) check("timeout_latency", cyc - rts_cyc, TMO + 1);
                        dev_frames.delete();
                        inh_runs.delete();
                        post_pending = 1;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < BUDGET && !tx_ready; i++) @(negedge clk);
    endtask

    task automatic send_start(input logic [7:0] d, input int mode);
        exp_t e;
        int   att;
        att = 1;
`ifdef PS2_TX_RETRY_EN
        att = RETRY + 1;
`endif
        e.bits       = ref_frame(d);
        e.is_done    = (mode == 0);
        e.is_timeout = (mode == 2);
        e.attempts   = (mode == 0) ? 1 : att;
        e.frames     = (mode == 0) ? 1 : ((mode == 1) ? att : 0);
        wait_ready();
        @(negedge clk);
        dev_mode  = mode;
        dev_falls = 0;
        exp_q.push_back(e);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3 * BUDGET; i++) begin
            if (exp_q.size() == 0 && !post_pending && !dev_busy && tx_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("transfer_completed", ok, 1);
        if (!ok) exp_q.delete();
    endtask

    task automatic send_wait(input logic [7:0] d, input int mode);
        send_start(d, mode);
        wait_quiet();
    endtask

    initial begin
        bit ok;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_tx_done", tx_done, 0);
        check("reset_tx_error", tx_error, 0);
        check("reset_clk_oe", clk_oe, 0);
        check("reset_data_oe", data_oe, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_wait(8'hED, 0);
        send_wait(8'hF4, 0);
        send_wait(8'h00, 0);
        for (int i = 0; i < 6; i++) send_wait(8'($urandom_range(0, 255)), 0);

        send_wait(8'($urandom_range(0, 255)), 1);   // NACK
        send_wait(8'hF4, 2);                        // device never clocks

        // Reset in the middle of a frame.
        wait_ready();
        @(negedge clk);
        dev_mode  = 0;
        dev_falls = 0;
        tx_data   = 8'hA5;
        tx_valid  = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (dev_falls >= 5) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("reached_fall5", ok, 1);
        rst = 1'b1;
        #1;
        check("midreset_clk_oe", clk_oe, 0);
        check("midreset_data_oe", data_oe, 0);
        check("midreset_tx_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < BUDGET && dev_busy; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        dev_frames.delete();
        inh_runs.delete();
        send_wait(8'hFF, 0);

        // tx_valid during DATA must be ignored.
        send_start(8'hF4, 0);
        for (int i = 0; i < BUDGET && dev_falls < 3; i++) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_during_data", busy, 1);
        wait_quiet();
        repeat (300) @(negedge clk);
        check("no_second_frame", inh_runs.size(), 0);
        check("idle_after_ignore", {tx_ready, clk_oe, data_oe}, 3'b100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the existing keyboard receiver and shares the same ps2_clock/ps2_data lines.
- Sends command bytes to the keyboard: 0xED LED set, 0xFF reset, 0xF4 enable.
- Frame sequence: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, then sample the device ACK.
- Drives lines open-drain through active-high pull-low enables, which the top level turns into tri-states.

Parameters:
- INHIBIT_CYCLES, default 6000: clock-low hold before request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, default 1000000: abort limit in clock cycles (20 ms) from request-to-send to frame end.
- MAX_RETRY, default 2: extra attempts after a failure; used only with PS2_TX_RETRY_EN.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous reset, active-high.
- tx_valid  in  1  send request.
- tx_data  in  8  byte to send.
- tx_ready  out  1  high in IDLE; a transfer is accepted when tx_valid & tx_ready.
- busy  out  1  equals ~tx_ready; the receiver uses it to ignore the line.
- tx_done  out  1  one-cycle pulse: device ACKed.
- tx_error  out  1  one-cycle pulse: NACK or timeout.
- ps2_clk_in  in  1  raw PS/2 clock pin.
- ps2_data_in  in  1  raw PS/2 data pin.
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_error=0, state=IDLE, counters=0.
- Reset asserted mid-frame releases both lines immediately (async) and drops the frame.
- ps2_clk_in and ps2_data_in pass through 2-flop synchronizers.
- fall = prev_sync_clk & ~sync_clk, where prev_sync_clk is a third flop. Pin-to-fall latency is 3 cycles.
- On acceptance, latch shift register {parity, tx_data}. parity = ~^tx_data (odd).
- Next cycle is INHIBIT, with ps2_clk_oe=1.
- tx_valid while busy is ignored; no queueing.
- State machine:
  - IDLE: both oe=0. On accept, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles. Then data_oe=1 (start bit), and the following cycle clk_oe=0. Go to RTS and clear the timeout counter.
  - RTS: wait for fall #1. On it, data_oe = ~bit0 and bit counter = 1. Go to DATA.
  - DATA: on each fall, drive the next bit (data_oe = ~bit). After fall #8 drives bit7, fall #9 drives parity. Go to STOP.
  - STOP: on fall #10, release data (data_oe=0). Go to ACK.
  - ACK: on fall #11, sample sync_data. If 0, go to WAIT_IDLE. If 1, it is a NACK: go to FAIL.
  - WAIT_IDLE: when sync_clk=1 and sync_data=1, pulse tx_done and go to IDLE.
  - FAIL: both oe=0, pulse tx_error, go to IDLE.
- Timeout counter runs from RTS entry through WAIT_IDLE. On reaching TIMEOUT_CYCLES, release both lines and go to FAIL.
- tx_ready returns high in the cycle after the tx_done or tx_error pulse.
- Fall events are ignored in IDLE and INHIBIT, since the host holds the clock itself.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - A NACK or timeout restarts from INHIBIT with the latched byte, up to MAX_RETRY times.
  - tx_error pulses only after the final attempt fails.
  - The attempt counter (2 bits) clears on accept.
- Undefined:
  - The first failure pulses tx_error.
  - MAX_RETRY is unused.

Test Plan:
- Send 0xED; device model clocks at 80 us period (4000 cycles) and ACKs.
  - clk_oe high for 6000 cycles, then data_oe=1.
  - Bits observed at device rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done is a single pulse; busy drops.
- Send 0xF4: bits 0,0,1,0,1,1,1,1, parity 0. Then send 0x00: parity 1.
- Device drives data high at fall #11 (NACK) → tx_error single pulse, lines released.
  - With PS2_TX_RETRY_EN: 3 INHIBIT phases occur, then one tx_error.
- Device never clocks after RTS → after 1000000 cycles: tx_error, data_oe=0, tx_ready=1.
- Assert reset at fall #5 of a frame → both oe=0 in the same cycle and tx_ready=1. Then a new 0xFF send completes with parity 1.
- Pulse tx_valid during DATA with tx_data=0x55 → ignored. The frame in flight finishes unchanged and no second frame starts.
